// File: rtl/keymatrix_scan.sv
// keymatrix_scan: PS/2-to-matrix keyboard emulator with a loadable scancode map and a timed key-injection FIFO.
// Build option KEYMATRIX_GHOST_EN adds one level of matrix ghosting to the column sense.
module keymatrix_scan #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int INJ_DEPTH = 16,
    parameter int HOLD_CYC  = 20000,
    parameter int GAP_CYC   = 20000,
    localparam int POS_W    = $clog2(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [10:0]      ps2_key,
    input  logic             map_we,
    input  logic [8:0]       map_addr,
    input  logic [POS_W:0]   map_data,
    input  logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  kbus,
    input  logic             inj_valid,
    input  logic [POS_W-1:0] inj_pos,
    output logic             inj_ready,
    output logic             inj_busy,
    input  logic             clear_all,
    output logic             any_key
);
    localparam int NKEYS = ROWS * COLS;
    localparam int NSLOT = 1 << POS_W;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int PTR_W = $clog2(INJ_DEPTH);
    localparam int MAXC  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CNT_W = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} inj_state_e;

    logic [POS_W:0]   map_mem [512];
    logic [511:0]     map_written_q, map_written_d;
    logic             ps2_s1_q, ps2_s2_q, ps2_evt;
    logic             lk_evt_q, lk_pressed_q, lk_written_q;
    logic [POS_W:0]   lk_ent_q;
    logic [POS_W-1:0] lk_pos;
    logic [NSLOT-1:0] pos_ok, key_q, key_d, eff;
    logic [COLS-1:0]  kbus_q, kbus_d;
    logic             any_q, any_d, sense;

    logic [POS_W-1:0] fifo_mem [INJ_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             fifo_full, fifo_empty, push, pop;

    inj_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [POS_W-1:0] inj_cur_q;
    logic             inj_active_q;

    assign ps2_evt = ps2_s1_q ^ ps2_s2_q;
    assign lk_pos  = lk_ent_q[POS_W-1:0];

    // Map contents are never reset; the written flags make unloaded entries read invalid.
    always_ff @(posedge clk) begin
        if (map_we)
            map_mem[map_addr] <= map_data;
        lk_ent_q <= map_mem[ps2_key[8:0]];
        if (push)
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= inj_pos;
    end

    always_comb begin
        for (int unsigned p = 0; p < NSLOT; p++)
            pos_ok[POS_W'(p)] = (p < NKEYS);
    end

    always_comb begin
        map_written_d = map_written_q;
        if (map_we)
            map_written_d[map_addr] = 1'b1;
        key_d = key_q;
        if (clear_all)
            key_d = '0;
        else if (lk_evt_q && lk_written_q && lk_ent_q[POS_W] && pos_ok[lk_pos])
            key_d[lk_pos] = lk_pressed_q;
    end

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        push       = inj_valid && !fifo_full;
        pop        = (state_q == IDLE) && !fifo_empty;
        wr_ptr_d   = wr_ptr_q + (PTR_W + 1)'(push);
        rd_ptr_d   = rd_ptr_q + (PTR_W + 1)'(pop);
    end

    always_comb begin
        eff = key_q;
        if (inj_active_q)
            eff[inj_cur_q] = 1'b1;
    end

    always_comb begin
        kbus_d = '1;
        sense  = 1'b0;
        for (int unsigned c = 0; c < COLS; c++) begin
            sense = 1'b0;
            for (int unsigned r = 0; r < ROWS; r++)
                sense = sense | (eff[POS_W'(r * COLS + c)] & ~row[RW'(r)]);
`ifdef KEYMATRIX_GHOST_EN
            // Sneak path: selected row -> shared column c2 -> other row r2 -> column c.
            for (int unsigned r = 0; r < ROWS; r++)
                for (int unsigned r2 = 0; r2 < ROWS; r2++)
                    for (int unsigned c2 = 0; c2 < COLS; c2++)
                        if (r2 != r && c2 != c)
                            sense = sense | (~row[RW'(r)] &
                                             eff[POS_W'(r * COLS + c2)] &
                                             eff[POS_W'(r2 * COLS + c2)] &
                                             eff[POS_W'(r2 * COLS + c)]);
`endif
            kbus_d[CW'(c)] = ~sense;
        end
        any_d = |(eff & pos_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2_s1_q      <= 1'b0;
            ps2_s2_q      <= 1'b0;
            lk_evt_q      <= 1'b0;
            lk_pressed_q  <= 1'b0;
            lk_written_q  <= 1'b0;
            map_written_q <= '0;
            key_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            kbus_q        <= '1;
            any_q         <= 1'b0;
        end else begin
            ps2_s1_q      <= ps2_key[10];
            ps2_s2_q      <= ps2_s1_q;
            lk_evt_q      <= ps2_evt;
            lk_pressed_q  <= ps2_key[9];
            lk_written_q  <= map_written_q[ps2_key[8:0]];
            map_written_q <= map_written_d;
            key_q         <= key_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            kbus_q        <= kbus_d;
            any_q         <= any_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            inj_cur_q    <= '0;
            inj_active_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        inj_cur_q    <= fifo_mem[rd_ptr_q[PTR_W-1:0]];
                        cnt_q        <= CNT_W'(HOLD_CYC - 1);
                        inj_active_q <= 1'b1;
                        state_q      <= PRESS;
                    end
                end
                PRESS: begin
                    if (cnt_q == '0) begin
                        inj_active_q <= 1'b0;
                        cnt_q        <= CNT_W'(GAP_CYC - 1);
                        state_q      <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == '0)
                        state_q <= IDLE;
                    else
                        cnt_q <= cnt_q - CNT_W'(1);
                end
                default: begin
                    inj_active_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign kbus      = kbus_q;
    assign any_key   = any_q;
    assign inj_ready = !fifo_full;
    assign inj_busy  = !fifo_empty || (state_q != IDLE);

endmodule
